// File: rtl/dz_pkg.sv
// ---------------------------------------------------------------------------
// dz_pkg
// Shared types and constants for the dot-matrix countdown controller.
//   dz_state_t   : controller state (IDLE, RUN, PAUSE, DONE)
//   DZ_BLANK     : digit code that the show block renders as an empty matrix
//   DZ_MAX_DIGIT : highest digit the show block can render
// ---------------------------------------------------------------------------
package dz_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } dz_state_t;

    localparam logic [2:0] DZ_BLANK     = 3'd7;
    localparam logic [2:0] DZ_MAX_DIGIT = 3'd5;

endpackage

// File: rtl/dz_prescaler.sv
// ---------------------------------------------------------------------------
// dz_prescaler
// Modulo-N cycle counter with a terminal-count pulse.
//   clk : system clock
//   rst : synchronous active-low reset
//   en  : count enable; the counter holds its value while low
//   clr : synchronous clear back to 0, wins over en
//   tc  : high for the cycle in which the counter sits at N-1 while enabled;
//         the counter wraps to 0 on the edge ending that cycle
// ---------------------------------------------------------------------------
module dz_prescaler #(
    parameter int N = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt;

    assign tc = en && (cnt == W'(N - 1));

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of the
    // order in which simulators evaluate the always blocks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/dz_count_ctrl.sv
// ---------------------------------------------------------------------------
// dz_count_ctrl
// Countdown sequencer for the 8x8 dot-matrix digit display. Counts from
// START_VAL down to 0 once per CLK_HZ cycles, controlled by start, pause and
// clear keys, then blinks digit 0 against the blank code.
//   clk       : 1 kHz system clock shared with the display scan
//   rst       : synchronous active-low reset
//   key_start : start / resume key (debounced level)
//   key_pause : pause / resume toggle key (debounced level)
//   key_clear : abort / reload key (debounced level)
//   num       : digit code for the show block, 0..5 or DZ_BLANK
//   running   : high while counting
//   done      : high while the countdown has expired and the display blinks
//   tick      : one-cycle pulse, aligned with num, on every decrement
// ---------------------------------------------------------------------------
module dz_count_ctrl
    import dz_pkg::*;
#(
    parameter int CLK_HZ     = 1000,
    parameter int START_VAL  = 5,
    parameter int BLINK_HALF = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       key_clear,
    output logic [2:0] num,
    output logic       running,
    output logic       done,
    output logic       tick
);

    // An out-of-range reload value is clamped to the largest renderable digit.
    localparam logic [2:0] START_Q =
        (START_VAL > int'(DZ_MAX_DIGIT)) ? DZ_MAX_DIGIT : 3'(START_VAL);

    dz_state_t  state, state_d;
    logic [2:0] count, count_d;
    logic       key_start_q, key_pause_q, key_clear_q;
    logic       start_edge, pause_edge, clear_edge;
    logic       sec_tc, sec_clr;
    logic       blink_tc, blink_phase, phase_d;
    logic       tick_d;
    logic [2:0] num_d;

    assign start_edge = key_start & ~key_start_q;
    assign pause_edge = key_pause & ~key_pause_q;
    assign clear_edge = key_clear & ~key_clear_q;

    // Second timer: advances only in RUN, so PAUSE keeps the partial second.
    dz_prescaler #(.N(CLK_HZ)) u_sec (
        .clk (clk),
        .rst (rst),
        .en  (state == RUN),
        .clr (sec_clr),
        .tc  (sec_tc)
    );

    // Blink timer: held at 0 whenever the controller is not staying in DONE,
    // so each visit to DONE starts with a full phase-0 half-period.
    dz_prescaler #(.N(BLINK_HALF)) u_blink (
        .clk (clk),
        .rst (rst),
        .en  (state == DONE),
        .clr (state_d != DONE),
        .tc  (blink_tc)
    );

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        count_d = count;
        tick_d  = 1'b0;
        sec_clr = 1'b0;

        if (clear_edge) begin
            // Clear outranks everything, including a coincident terminal count.
            state_d = IDLE;
            count_d = START_Q;
            sec_clr = 1'b1;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (state == DONE) count_d = '0;
                    if (start_edge) begin
                        count_d = START_Q;
                        sec_clr = 1'b1;
                        state_d = (START_Q == 3'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (sec_tc) begin
                        tick_d = 1'b1;
                        if (count != 3'd0) count_d = count - 3'd1;
                        // Reaching zero outranks a coincident pause.
                        if (count <= 3'd1) state_d = DONE;
                        else if (pause_edge) state_d = PAUSE;
                    end else if (pause_edge) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_edge || pause_edge) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end

        phase_d = 1'b0;
        if (state_d == DONE) phase_d = blink_tc ? ~blink_phase : blink_phase;

        num_d = count_d;
        if (state_d == DONE) num_d = phase_d ? DZ_BLANK : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= START_Q;
            blink_phase <= 1'b0;
            key_start_q <= 1'b0;
            key_pause_q <= 1'b0;
            key_clear_q <= 1'b0;
            num         <= START_Q;
            running     <= 1'b0;
            done        <= 1'b0;
            tick        <= 1'b0;
        end else begin
            state       <= state_d;
            count       <= count_d;
            blink_phase <= phase_d;
            key_start_q <= key_start;
            key_pause_q <= key_pause;
            key_clear_q <= key_clear;
            num         <= num_d;
            running     <= (state_d == RUN);
            done        <= (state_d == DONE);
            tick        <= tick_d;
        end
    end

endmodule

// File: tb/tb_dz_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dz_count_ctrl
// Scoreboard bench for dz_count_ctrl (CLK_HZ=10, START_VAL=5, BLINK_HALF=4).
// The stimulus process steps a behavioural model of the countdown once per
// cycle and queues the outputs expected after the next rising edge; a monitor
// compares them on the falling edge when they fall due.
// ---------------------------------------------------------------------------
module tb_dz_count_ctrl;

    localparam int CLK_HZ     = 10;
    localparam int START_VAL  = 5;
    localparam int BLINK_HALF = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_start = 1'b0;
    logic       key_pause = 1'b0;
    logic       key_clear = 1'b0;
    logic [2:0] num;
    logic       running;
    logic       done;
    logic       tick;

    dz_count_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .START_VAL  (START_VAL),
        .BLINK_HALF (BLINK_HALF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_start (key_start),
        .key_pause (key_pause),
        .key_clear (key_clear),
        .num       (num),
        .running   (running),
        .done      (done),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int num;
        bit running;
        bit done;
        bit tick;
    } exp_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: mode, digit, cycles elapsed in the current second,
    // cycles spent in DONE, previous key levels.
    int m_mode  = M_IDLE;
    int m_count = START_VAL;
    int m_ms    = 0;
    int m_blink = 0;
    bit m_tick  = 1'b0;
    bit m_ps = 1'b0, m_pp = 1'b0, m_pc = 1'b0;

    task automatic model_step(input bit r, input bit ks, input bit kp, input bit kc);
        bit es, ep, ec;
        m_tick = 1'b0;
        if (!r) begin
            m_mode = M_IDLE; m_count = START_VAL; m_ms = 0; m_blink = 0;
            m_ps = 1'b0; m_pp = 1'b0; m_pc = 1'b0;
            return;
        end
        es = ks && !m_ps; ep = kp && !m_pp; ec = kc && !m_pc;
        m_ps = ks; m_pp = kp; m_pc = kc;
        if (ec) begin
            m_mode = M_IDLE; m_count = START_VAL; m_ms = 0; m_blink = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (es) begin
                    m_ms = 0; m_blink = 0;
                    m_mode = (START_VAL == 0) ? M_DONE : M_RUN;
                end
            end
            M_RUN: begin
                m_ms = (m_ms + 1) % CLK_HZ;
                if (m_ms == 0) begin
                    m_tick  = 1'b1;
                    m_count = m_count - 1;
                    if (m_count == 0) begin
                        m_mode = M_DONE; m_blink = 0;
                    end else if (ep) begin
                        m_mode = M_PAUSE;
                    end
                end else if (ep) begin
                    m_mode = M_PAUSE;
                end
            end
            M_PAUSE: begin
                if (es || ep) m_mode = M_RUN;
            end
            default: begin
                if (es) begin
                    m_count = START_VAL; m_ms = 0; m_mode = M_RUN;
                end else begin
                    m_blink = m_blink + 1;
                end
            end
        endcase
    endtask

    // One clock cycle: apply inputs after the edge, step the model and queue
    // the outputs expected once the next edge has taken effect.
    task automatic drive(input bit r, input bit ks, input bit kp, input bit kc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; key_start = ks; key_pause = kp; key_clear = kc;
        model_step(r, ks, kp, kc);
        e.due     = cyc + 1;
        e.running = (m_mode == M_RUN);
        e.done    = (m_mode == M_DONE);
        e.tick    = m_tick;
        if (m_mode == M_DONE) e.num = ((m_blink / BLINK_HALF) % 2 == 1) ? 7 : 0;
        else                  e.num = m_count;
        sb_q.push_back(e);
    endtask

    // Idle the keys until the model reaches the requested mode/digit (and
    // prescaler position when ms >= 0), within a cycle budget.
    task automatic wait_for(input int mode, input int count, input int ms);
        int n = 0;
        while (!(m_mode == mode && m_count == count && (ms < 0 || m_ms == ms)) && n < 400) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL wait_for: budget expired, mode=%0d count=%0d, wanted mode=%0d count=%0d",
                     m_mode, m_count, mode, count);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                checks++;
                if (int'(num) != e.num || running !== e.running ||
                    done !== e.done || tick !== e.tick) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d: got num=%0d running=%0b done=%0b tick=%0b, expected num=%0d running=%0b done=%0b tick=%0b",
                             cyc, num, running, done, tick, e.num, e.running, e.done, e.tick);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit ks, kp, kc, rs;
        int r;

        // Reset state.
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Full countdown 5..0, then blinking in DONE.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (70) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Restart from DONE, pause mid-second, hold, resume.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (15) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (30) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (12) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Clear, restart, then clear coincident with the 3->2 terminal count.
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        wait_for(M_RUN, 3, CLK_HZ - 1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Held start gives a single start; after clear it must be re-pressed.
        repeat (100) drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (30) drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset while counting at digit 2.
        wait_for(M_RUN, 2, -1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (15) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Random key traffic: at most one key level changes per cycle,
        // with rare resets.
        ks = 1'b0; kp = 1'b0; kc = 1'b0;
        repeat (3000) begin
            r = $urandom_range(0, 999);
            if (r < 30)      ks = ~ks;
            else if (r < 60) kp = ~kp;
            else if (r < 70) kc = ~kc;
            rs = (r >= 997) ? 1'b0 : 1'b1;
            drive(rs, ks, kp, kc);
        end

        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries never compared, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
